pwrok_handshake_monitor: RTL and testbench

//  Far-end checker for the PCH power-good handshake. Watches PCH_PWROK/SYS_PWROK going out and CPUPWRGD coming back from the PCH.

---
 rtl/pwrok_handshake_monitor.sv | 137 +++++++++++++
 tb/tb_pwrok_handshake_monitor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwrok_handshake_monitor.sv
// Far-end checker for the PCH power-good handshake: times CPUPWRGD after PCH_PWROK,
// supervises rail power-goods in S0, and latches a sticky fault code with a force-off request.
module pwrok_handshake_monitor #(
  parameter int TIMER_BITS     = 8,
  parameter int CPUPWRGD_TO_MS = 100,
  parameter int DEGLITCH_CLKS  = 4
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       i1mSCE,
  input  logic       iPchPwrok,
  input  logic       iSysPwrok,
  input  logic       iCpuPwrgd,
  input  logic       iSlpS3_n,
  input  logic       iMemPwrgd,
  input  logic       iCpuVrPwrgd,
  input  logic       iBmcPwrgd,
  input  logic       iPchVrPwrgd,
  output logic       oFault,
  output logic       oForceOff,
  output logic [3:0] ovFaultCode,
  output logic       oInS0
);

  localparam int DG_BITS = $clog2(DEGLITCH_CLKS + 1);
  localparam logic [TIMER_BITS-1:0] TIMEOUT_LAST = TIMER_BITS'(CPUPWRGD_TO_MS - 1);
  localparam logic [DG_BITS-1:0]    DG_MAX       = DG_BITS'(DEGLITCH_CLKS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_CPU = 3'd1,
    RUN      = 3'd2,
    FAULT    = 3'd3
  } state_e;

  state_e                stateQ, stateNext;
  logic [TIMER_BITS-1:0] timerQ, timerNext;
  logic [DG_BITS-1:0]    dgQ, dgNext;
  logic [3:0]            codeQ, codeNext;
  logic                  pwrokQ;

  logic       pwrokRise;
  logic       anyRailLow;
  logic [3:0] railCode;

  assign pwrokRise  = iPchPwrok & ~pwrokQ;
  assign anyRailLow = ~(iMemPwrgd & iCpuVrPwrgd & iBmcPwrgd & iPchVrPwrgd);

  // Lowest-numbered rail that is low wins the fault code.
  always_comb begin
    railCode = 4'h0;
    if      (!iMemPwrgd)   railCode = 4'h2;
    else if (!iCpuVrPwrgd) railCode = 4'h3;
    else if (!iBmcPwrgd)   railCode = 4'h4;
    else if (!iPchVrPwrgd) railCode = 4'h5;
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    stateNext = stateQ;
    timerNext = timerQ;
    dgNext    = dgQ;
    codeNext  = codeQ;
    case (stateQ)
      IDLE: begin
        timerNext = '0;
        dgNext    = '0;
        if (pwrokRise && iSlpS3_n) begin
          stateNext = WAIT_CPU;
          codeNext  = 4'h0;
        end
      end
      WAIT_CPU: begin
        if (i1mSCE && (timerQ != '1)) timerNext = timerQ + TIMER_BITS'(1);
        if (!iSlpS3_n || !iPchPwrok) begin
          stateNext = IDLE;
        end else if (iCpuPwrgd) begin
          stateNext = RUN;
        end else if (i1mSCE && (timerQ == TIMEOUT_LAST)) begin
          stateNext = FAULT;
          codeNext  = 4'h1;
        end
      end
      RUN: begin
        if (!anyRailLow)       dgNext = '0;
        else if (dgQ != DG_MAX) dgNext = dgQ + DG_BITS'(1);
        if (!iSlpS3_n) begin
          stateNext = IDLE;
        end else if (anyRailLow && (dgNext == DG_MAX)) begin
          stateNext = FAULT;
          codeNext  = railCode;
        end else if (!iCpuPwrgd && iPchPwrok) begin
          stateNext = FAULT;
          codeNext  = 4'h6;
        end else if (!iPchPwrok || !iSysPwrok) begin
          stateNext = FAULT;
          codeNext  = 4'h7;
        end
      end
      FAULT: begin
        // Counters stay frozen here; the IDLE state clears them.
        if (!iSlpS3_n && !iPchPwrok) stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
        timerNext = '0;
        dgNext    = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      stateQ      <= IDLE;
      timerQ      <= '0;
      dgQ         <= '0;
      codeQ       <= 4'h0;
      pwrokQ      <= 1'b0;
      oFault      <= 1'b0;
      oForceOff   <= 1'b0;
      ovFaultCode <= 4'h0;
      oInS0       <= 1'b0;
    end else begin
      stateQ      <= stateNext;
      timerQ      <= timerNext;
      dgQ         <= dgNext;
      codeQ       <= codeNext;
      pwrokQ      <= iPchPwrok;
      oFault      <= (stateQ == FAULT);
      oForceOff   <= (stateQ == FAULT);
      ovFaultCode <= codeQ;
      oInS0       <= (stateQ == RUN);
    end
  end

endmodule

// File: tb/tb_pwrok_handshake_monitor.sv
// Directed bench for pwrok_handshake_monitor: timeout race, missing CPUPWRGD, deglitch,
// orderly exit, PWROK loss, CPUPWRGD loss and asynchronous reset.
module tb_pwrok_handshake_monitor;

  logic       iClk = 1'b0;
  logic       iRst;
  logic       i1mSCE;
  logic       iPchPwrok;
  logic       iSysPwrok;
  logic       iCpuPwrgd;
  logic       iSlpS3_n;
  logic       iMemPwrgd;
  logic       iCpuVrPwrgd;
  logic       iBmcPwrgd;
  logic       iPchVrPwrgd;
  logic       oFault;
  logic       oForceOff;
  logic [3:0] ovFaultCode;
  logic       oInS0;

  int testsRun    = 0;
  int testsFailed = 0;

  pwrok_handshake_monitor #(
    .TIMER_BITS    (8),
    .CPUPWRGD_TO_MS(100),
    .DEGLITCH_CLKS (4)
  ) dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .i1mSCE     (i1mSCE),
    .iPchPwrok  (iPchPwrok),
    .iSysPwrok  (iSysPwrok),
    .iCpuPwrgd  (iCpuPwrgd),
    .iSlpS3_n   (iSlpS3_n),
    .iMemPwrgd  (iMemPwrgd),
    .iCpuVrPwrgd(iCpuVrPwrgd),
    .iBmcPwrgd  (iBmcPwrgd),
    .iPchVrPwrgd(iPchVrPwrgd),
    .oFault     (oFault),
    .oForceOff  (oForceOff),
    .ovFaultCode(ovFaultCode),
    .oInS0      (oInS0)
  );

  always #5 iClk = ~iClk;

  task automatic checkVal(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the edge for driving/sampling.
  task automatic step(input int n);
    repeat (n) @(posedge iClk);
    #1;
  endtask

  task automatic msTick();
    i1mSCE = 1'b1;
    step(1);
    i1mSCE = 1'b0;
  endtask

  task automatic setRails(input logic mem, input logic cpuVr, input logic bmc, input logic pchVr);
    iMemPwrgd   = mem;
    iCpuVrPwrgd = cpuVr;
    iBmcPwrgd   = bmc;
    iPchVrPwrgd = pchVr;
  endtask

  // From IDLE with PWROK low: raise SLPS3, then PWROK, then CPUPWRGD.
  task automatic enterRun();
    iSlpS3_n = 1'b1;
    iSysPwrok = 1'b1;
    step(1);
    iPchPwrok = 1'b1;
    step(1);
    iCpuPwrgd = 1'b1;
    step(3);
  endtask

  task automatic orderlyOff();
    iSlpS3_n  = 1'b0;
    iPchPwrok = 1'b0;
    iCpuPwrgd = 1'b0;
    step(3);
  endtask

  initial begin
    iRst = 1'b1;
    i1mSCE = 1'b0;
    iPchPwrok = 1'b0;
    iSysPwrok = 1'b0;
    iCpuPwrgd = 1'b0;
    iSlpS3_n = 1'b0;
    setRails(1'b1, 1'b1, 1'b1, 1'b1);
    step(2);
    checkVal("rst_fault", oFault, 0);
    checkVal("rst_forceoff", oForceOff, 0);
    checkVal("rst_code", ovFaultCode, 4'h0);
    checkVal("rst_ins0", oInS0, 0);
    iRst = 1'b0;
    step(2);

    // Timeout race: CPUPWRGD arrives on the 100th ms tick.
    iSlpS3_n = 1'b1;
    iSysPwrok = 1'b1;
    step(2);
    iPchPwrok = 1'b1;
    step(1);
    repeat (99) msTick();
    step(2);
    checkVal("race_pre_fault", oFault, 0);
    checkVal("race_pre_ins0", oInS0, 0);
    iCpuPwrgd = 1'b1;
    msTick();
    step(2);
    checkVal("race_ins0", oInS0, 1);
    checkVal("race_fault", oFault, 0);
    checkVal("race_code", ovFaultCode, 4'h0);

    // Unexpected SYS_PWROK loss in RUN.
    iSysPwrok = 1'b0;
    step(3);
    checkVal("sys_loss_code", ovFaultCode, 4'h7);
    checkVal("sys_loss_forceoff", oForceOff, 1);
    checkVal("sys_loss_ins0", oInS0, 0);
    iSlpS3_n = 1'b0;
    iPchPwrok = 1'b0;
    iCpuPwrgd = 1'b0;
    step(3);
    checkVal("sys_loss_exit_fault", oFault, 0);
    checkVal("sys_loss_sticky", ovFaultCode, 4'h7);
    iSlpS3_n = 1'b1;
    iSysPwrok = 1'b1;
    step(1);
    iPchPwrok = 1'b1;
    step(3);
    checkVal("reentry_code", ovFaultCode, 4'h0);
    checkVal("reentry_wait_ins0", oInS0, 0);
    iCpuPwrgd = 1'b1;
    step(3);
    checkVal("reentry_run", oInS0, 1);

    // Deglitch: 3 clocks low is tolerated, 4 clocks faults with the lowest rail code.
    setRails(1'b1, 1'b1, 1'b0, 1'b1);
    step(3);
    setRails(1'b1, 1'b1, 1'b1, 1'b1);
    step(3);
    checkVal("dg3_fault", oFault, 0);
    checkVal("dg3_ins0", oInS0, 1);
    setRails(1'b0, 1'b1, 1'b0, 1'b1);
    step(3);
    checkVal("dg_pre_fault", oFault, 0);
    step(1);
    setRails(1'b1, 1'b1, 1'b1, 1'b1);
    step(2);
    checkVal("dg4_fault", oFault, 1);
    checkVal("dg4_code", ovFaultCode, 4'h2);
    orderlyOff();
    checkVal("dg_exit_fault", oFault, 0);
    checkVal("dg_exit_sticky", ovFaultCode, 4'h2);

    // CPUPWRGD never arrives.
    iSlpS3_n = 1'b1;
    step(1);
    iPchPwrok = 1'b1;
    step(1);
    repeat (99) msTick();
    step(2);
    checkVal("to_pre_fault", oFault, 0);
    msTick();
    step(2);
    checkVal("to_fault", oFault, 1);
    checkVal("to_forceoff", oForceOff, 1);
    checkVal("to_code", ovFaultCode, 4'h1);
    iSlpS3_n = 1'b0;
    iPchPwrok = 1'b0;
    step(3);
    checkVal("to_exit_fault", oFault, 0);
    checkVal("to_exit_forceoff", oForceOff, 0);
    checkVal("to_exit_code", ovFaultCode, 4'h1);

    // Orderly exit beats the PWROK/CPUPWRGD faults in the same cycle.
    enterRun();
    checkVal("ord_ins0", oInS0, 1);
    checkVal("ord_code_clr", ovFaultCode, 4'h0);
    orderlyOff();
    checkVal("ord_ins0_off", oInS0, 0);
    checkVal("ord_fault", oFault, 0);
    checkVal("ord_code", ovFaultCode, 4'h0);

    // CPUPWRGD drop with PCH_PWROK still high.
    enterRun();
    iCpuPwrgd = 1'b0;
    step(3);
    checkVal("cpu_loss_code", ovFaultCode, 4'h6);
    checkVal("cpu_loss_fault", oFault, 1);
    orderlyOff();

    // Async reset while in FAULT with code 3.
    enterRun();
    setRails(1'b1, 1'b0, 1'b1, 1'b0);
    step(4);
    setRails(1'b1, 1'b1, 1'b1, 1'b1);
    step(2);
    checkVal("cpuvr_code", ovFaultCode, 4'h3);
    checkVal("cpuvr_fault", oFault, 1);
    #2;
    iRst = 1'b1;
    #1;
    checkVal("arst_fault", oFault, 0);
    checkVal("arst_forceoff", oForceOff, 0);
    checkVal("arst_code", ovFaultCode, 4'h0);
    checkVal("arst_ins0", oInS0, 0);
    step(2);
    checkVal("arst_hold_code", ovFaultCode, 4'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
